// File: rtl/fetch_stage.sv
// Fetch stage: PC generation, fetch-buffer request and instruction queue toward decode.

package fetch_stage_pkg;

    // Request toward the fetch buffer.
    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic        mem_spec;
        logic        mem_fence;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    // Response from the fetch buffer.
    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

    // One instruction-queue entry.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        comp;
    } queue_entry_t;

endpackage

module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] reset_vector = 32'h0000_0000,
    parameter int unsigned queue_depth  = 4
) (
    input  logic        clock,
    input  logic        reset,
    output mem_in_type  fetchbuffer_in,
    input  mem_out_type fetchbuffer_out,
    input  logic        redirect_valid,
    input  logic        redirect_fence,
    input  logic [31:0] redirect_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_comp
);

    localparam int unsigned ptr_w = (queue_depth > 1) ? $clog2(queue_depth) : 1;
    localparam int unsigned cnt_w = ptr_w + 1;

    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [0:0]       state_next;
    logic [31:0]      pc;
    logic [cnt_w-1:0] count;
    logic [ptr_w-1:0] head;
    logic [ptr_w-1:0] tail;
    queue_entry_t     queue [queue_depth];

    logic             enq;
    logic             deq;
    logic             rdata_comp;
    logic [31:0]      redirect_pc;
    queue_entry_t     head_entry;

    assign rdata_comp  = (fetchbuffer_out.mem_rdata[1:0] != 2'b11);
    assign redirect_pc = redirect_addr & ~32'h1;
    assign head_entry  = queue[head];

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next state, fetch request, queue handshake and decode outputs.
    always_comb begin
        state_next     = state;
        fetchbuffer_in = '0;
        fetchbuffer_in.mem_instr = 1'b1;
        enq            = 1'b0;
        deq            = 1'b0;
        out_valid      = 1'b0;
        out_pc         = '0;
        out_instr      = '0;
        out_comp       = 1'b0;

        if (redirect_valid) begin
            // Redirect outranks INIT and RUN; response is ignored this cycle.
            state_next               = RUN;
            fetchbuffer_in.mem_valid = 1'b1;
            fetchbuffer_in.mem_addr  = redirect_pc;
            fetchbuffer_in.mem_spec  = 1'b1;
            fetchbuffer_in.mem_fence = redirect_fence;
        end else begin
            case (state)
                INIT: begin
                    state_next = RUN;
                end
                RUN: begin
                    if (count < cnt_w'(queue_depth)) begin
                        fetchbuffer_in.mem_valid = 1'b1;
                        fetchbuffer_in.mem_addr  = pc;
                    end
                    enq = fetchbuffer_in.mem_valid && fetchbuffer_out.mem_ready;
                end
                default: begin
                    state_next = INIT;
                end
            endcase
        end

        out_valid = (count != '0) && !redirect_valid;
        deq       = out_valid && out_ready;
        if (out_valid) begin
            out_pc    = head_entry.pc;
            out_instr = head_entry.instr;
            out_comp  = head_entry.comp;
        end
    end

    // PC, queue pointers, occupancy and entry storage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc    <= reset_vector;
            count <= '0;
            head  <= '0;
            tail  <= '0;
            for (int i = 0; i < int'(queue_depth); i++) begin
                queue[i] <= '0;
            end
        end else if (redirect_valid) begin
            pc    <= redirect_pc;
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (enq) begin
                queue[tail].pc    <= pc;
                queue[tail].instr <= rdata_comp ? {16'h0000, fetchbuffer_out.mem_rdata[15:0]}
                                                : fetchbuffer_out.mem_rdata;
                queue[tail].comp  <= rdata_comp;
                tail              <= tail + ptr_w'(1);
                pc                <= pc + (rdata_comp ? 32'd2 : 32'd4);
            end
            if (deq) begin
                head <= head + ptr_w'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + cnt_w'(1);
                2'b01:   count <= count - cnt_w'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small fetch-buffer ROM model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    mem_in_type  fb_in;
    mem_out_type fb_out;
    logic        redirect_valid;
    logic        redirect_fence;
    logic [31:0] redirect_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_comp;

    logic        fb_ready;
    int          prog;
    int          total;
    int          bad;

    fetch_stage dut (
        .clock           (clk),
        .reset           (rst_n),
        .fetchbuffer_in  (fb_in),
        .fetchbuffer_out (fb_out),
        .redirect_valid  (redirect_valid),
        .redirect_fence  (redirect_fence),
        .redirect_addr   (redirect_addr),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .out_comp        (out_comp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory seen through the fetch buffer.
    function automatic logic [31:0] rom(input logic [31:0] a, input int p);
        if (p == 1) begin
            case (a)
                32'h0:   return 32'hABCD_4501;
                32'h2:   return 32'h0000_0013;
                32'h6:   return 32'h0000_8082;
                default: return 32'h0000_0013;
            endcase
        end
        return 32'h0000_0013;
    endfunction

    always_comb begin
        fb_out.mem_ready = fb_ready;
        fb_out.mem_rdata = rom(fb_in.mem_addr, prog);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_req(input string tag, input logic v, input logic [31:0] a);
        chk({tag, "_mem_valid"}, 32'(fb_in.mem_valid), 32'(v));
        if (v) chk({tag, "_mem_addr"}, fb_in.mem_addr, a);
    endtask

    // Assert reset, check the reset outputs, release mid-cycle into INIT.
    task automatic do_reset(input int p);
        rst_n = 1'b0;
        prog  = p;
        #1;
        chk("rst_mem_valid", 32'(fb_in.mem_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        prog           = 0;
        rst_n          = 1'b0;
        fb_ready       = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_fence = 1'b0;
        redirect_addr  = '0;

        // Straight-line 32-bit stream
        do_reset(0);
        chk("t1_rst_pc", out_pc, 32'h0);
        chk("t1_rst_addr", fb_in.mem_addr, 32'h0);
        chk_req("t1_init", 1'b0, 32'h0);
        tick();
        chk_req("t1_req0", 1'b1, 32'h0);
        chk("t1_ov0", 32'(out_valid), 32'd0);
        tick();
        chk_req("t1_req4", 1'b1, 32'h4);
        chk("t1_ov1", 32'(out_valid), 32'd1);
        chk("t1_pc0", out_pc, 32'h0);
        chk("t1_comp0", 32'(out_comp), 32'd0);
        chk("t1_instr0", out_instr, 32'h13);
        tick();
        chk_req("t1_req8", 1'b1, 32'h8);
        chk("t1_pc4", out_pc, 32'h4);
        tick();
        chk("t1_pc8", out_pc, 32'h8);
        chk("t1_comp8", 32'(out_comp), 32'd0);

        // Mixed compressed / full stream
        do_reset(1);
        tick();
        chk_req("t2_req0", 1'b1, 32'h0);
        tick();
        chk_req("t2_req2", 1'b1, 32'h2);
        chk("t2_pc0", out_pc, 32'h0);
        chk("t2_instr0", out_instr, 32'h0000_4501);
        chk("t2_comp0", 32'(out_comp), 32'd1);
        tick();
        chk_req("t2_req6", 1'b1, 32'h6);
        chk("t2_pc2", out_pc, 32'h2);
        chk("t2_instr2", out_instr, 32'h13);
        chk("t2_comp2", 32'(out_comp), 32'd0);
        tick();
        chk_req("t2_req8", 1'b1, 32'h8);
        chk("t2_pc6", out_pc, 32'h6);
        chk("t2_instr6", out_instr, 32'h0000_8082);
        chk("t2_comp6", 32'(out_comp), 32'd1);

        // Full queue blocks requests, not dequeue
        out_ready = 1'b0;
        do_reset(0);
        tick();
        chk_req("t3_req0", 1'b1, 32'h0);
        tick();
        chk_req("t3_req4", 1'b1, 32'h4);
        tick();
        chk_req("t3_req8", 1'b1, 32'h8);
        tick();
        chk_req("t3_reqc", 1'b1, 32'hC);
        tick();
        chk_req("t3_full", 1'b0, 32'h0);
        tick();
        chk_req("t3_full2", 1'b0, 32'h0);
        out_ready = 1'b1;
        #1;
        chk("t3_ov", 32'(out_valid), 32'd1);
        chk("t3_head", out_pc, 32'h0);
        tick();
        out_ready = 1'b0;
        #1;
        chk_req("t3_req10", 1'b1, 32'h10);
        chk("t3_head2", out_pc, 32'h4);

        // Redirect with three entries queued and buffer ready
        redirect_valid = 1'b1;
        redirect_addr  = 32'h101;
        #1;
        chk_req("t4_redir", 1'b1, 32'h100);
        chk("t4_spec", 32'(fb_in.mem_spec), 32'd1);
        chk("t4_fence", 32'(fb_in.mem_fence), 32'd0);
        chk("t4_ov", 32'(out_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        redirect_addr  = 32'hFFFF_FFFF;
        #1;
        chk("t4_flushed", 32'(out_valid), 32'd0);
        chk_req("t4_req100", 1'b1, 32'h100);
        chk("t4_spec_off", 32'(fb_in.mem_spec), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("t4_first_ov", 32'(out_valid), 32'd1);
        chk("t4_first_pc", out_pc, 32'h100);
        out_ready = 1'b0;

        // fence.i redirect followed by a stalled fetch buffer
        redirect_valid = 1'b1;
        redirect_fence = 1'b1;
        redirect_addr  = 32'h200;
        fb_ready       = 1'b0;
        #1;
        chk_req("t5_redir", 1'b1, 32'h200);
        chk("t5_fence", 32'(fb_in.mem_fence), 32'd1);
        chk("t5_spec", 32'(fb_in.mem_spec), 32'd1);
        chk("t5_ov", 32'(out_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        redirect_fence = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk_req("t5_stall", 1'b1, 32'h200);
            chk("t5_stall_fence", 32'(fb_in.mem_fence), 32'd0);
            chk("t5_stall_spec", 32'(fb_in.mem_spec), 32'd0);
            chk("t5_stall_ov", 32'(out_valid), 32'd0);
            tick();
        end
        redirect_fence = 1'b0;
        fb_ready = 1'b1;
        tick();
        chk("t5_resume_ov", 32'(out_valid), 32'd1);
        chk("t5_resume_pc", out_pc, 32'h200);

        // Redirect during INIT, then reset with entries queued
        do_reset(0);
        redirect_valid = 1'b1;
        redirect_addr  = 32'h38;
        #1;
        chk_req("t6_init_redir", 1'b1, 32'h38);
        chk("t6_init_spec", 32'(fb_in.mem_spec), 32'd1);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk_req("t6_req38", 1'b1, 32'h38);
        tick();
        tick();
        chk_req("t6_req40", 1'b1, 32'h40);
        chk("t6_ov", 32'(out_valid), 32'd1);
        chk("t6_head", out_pc, 32'h38);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ov", 32'(out_valid), 32'd0);
        chk("t6_rst_mv", 32'(fb_in.mem_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk_req("t6_init", 1'b0, 32'h0);
        chk("t6_init_ov", 32'(out_valid), 32'd0);
        tick();
        chk_req("t6_req_rv", 1'b1, 32'h0);
        chk("t6_no_stale", 32'(out_valid), 32'd0);
        tick();
        chk("t6_first_pc", out_pc, 32'h0);
        chk_req("t6_req4", 1'b1, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
